// File: rtl/pulse_capture_gate.sv
`default_nettype none
// ============================================================================
// Module      : pulse_capture_gate
// Description : Per-pulse sample gate for the radar receive chain. On each
//               accepted radar trigger it snapshots a 128-bit header
//               (trigger count, timestamp, azimuth counts, missed-trigger
//               count) and pulses init, then discards a programmable number
//               of strobed samples and forwards exactly n_samples strobed
//               samples before idling until the next trigger.
//
// Ports       : clock, reset      - system clock, async active-high reset
//               enable            - block enable; low forces IDLE
//               trig_in/acp_in/arp_in - raw asynchronous trigger / azimuth
//                                   count / azimuth reset pulses
//               data_in/strobe_in - decimated sample stream
//               delay/n_samples   - per-pulse skip / forward counts
//               init/meta_data    - header load pulse and header word
//               data_out/strobe_out - forwarded sample stream (latency 1)
//               busy              - high whenever not IDLE
//
// Revision    : 1.0 - initial release
// ============================================================================
module pulse_capture_gate #(
    parameter int DATA_WIDTH      = 16,
    parameter int META_DATA_WIDTH = 128,
    parameter int CNT_WIDTH       = 16
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       enable,
    input  logic                       trig_in,
    input  logic                       acp_in,
    input  logic                       arp_in,
    input  logic [DATA_WIDTH-1:0]      data_in,
    input  logic                       strobe_in,
    input  logic [CNT_WIDTH-1:0]       delay,
    input  logic [CNT_WIDTH-1:0]       n_samples,
    output logic                       init,
    output logic [META_DATA_WIDTH-1:0] meta_data,
    output logic [DATA_WIDTH-1:0]      data_out,
    output logic                       strobe_out,
    output logic                       busy
);

    localparam logic [15:0] c_MISSED_MAX = 16'hFFFF;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_INIT    = 2'd1,
        S_DELAY   = 2'd2,
        S_CAPTURE = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Input conditioning: bit 0 = trigger, bit 1 = ACP, bit 2 = ARP.
    // Two synchronizer flops, a history flop, and a registered edge so the
    // event pulse appears three clocks after the raw input rises.
    // ------------------------------------------------------------------
    logic [2:0] raw;
    logic [2:0] sync1_q;
    logic [2:0] sync2_q;
    logic [2:0] sync3_q;
    logic [2:0] edge_q;

    assign raw = {arp_in, acp_in, trig_in};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            sync3_q <= '0;
            edge_q  <= '0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
            edge_q  <= sync2_q & ~sync3_q;
        end
    end

    logic trig_edge;
    logic acp_edge;
    logic arp_edge;

    assign trig_edge = edge_q[0];
    assign acp_edge  = edge_q[1];
    assign arp_edge  = edge_q[2];

    // ------------------------------------------------------------------
    // Free-running counters; they keep running while the block is disabled
    // so the header always reflects true time and antenna position.
    // ------------------------------------------------------------------
    logic [31:0] ts_q;
    logic [15:0] acp_cnt_q;
    logic [15:0] arp_cnt_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ts_q      <= '0;
            acp_cnt_q <= '0;
            arp_cnt_q <= '0;
        end else begin
            ts_q <= ts_q + 32'd1;
            // A heading mark restarts the azimuth count even if an ACP
            // edge lands in the same cycle.
            if (arp_edge) begin
                acp_cnt_q <= '0;
                arp_cnt_q <= arp_cnt_q + 16'd1;
            end else if (acp_edge) begin
                acp_cnt_q <= acp_cnt_q + 16'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Pulse FSM and per-pulse registers
    // ------------------------------------------------------------------
    state_t                       state_q,      state_d;
    logic [CNT_WIDTH-1:0]         delay_cnt_q,  delay_cnt_d;
    logic [CNT_WIDTH-1:0]         samp_cnt_q,   samp_cnt_d;
    logic [31:0]                  trig_cnt_q,   trig_cnt_d;
    logic [15:0]                  missed_cnt_q, missed_cnt_d;
    logic [META_DATA_WIDTH-1:0]   meta_q,       meta_d;
    logic [DATA_WIDTH-1:0]        data_out_q,   data_out_d;
    logic                         strobe_out_q, strobe_out_d;
    logic                         accept;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            delay_cnt_q  <= '0;
            samp_cnt_q   <= '0;
            trig_cnt_q   <= '0;
            missed_cnt_q <= '0;
            meta_q       <= '0;
            data_out_q   <= '0;
            strobe_out_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            delay_cnt_q  <= delay_cnt_d;
            samp_cnt_q   <= samp_cnt_d;
            trig_cnt_q   <= trig_cnt_d;
            missed_cnt_q <= missed_cnt_d;
            meta_q       <= meta_d;
            data_out_q   <= data_out_d;
            strobe_out_q <= strobe_out_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        delay_cnt_d  = delay_cnt_q;
        samp_cnt_d   = samp_cnt_q;
        trig_cnt_d   = trig_cnt_q;
        missed_cnt_d = missed_cnt_q;
        meta_d       = meta_q;
        data_out_d   = data_out_q;
        strobe_out_d = 1'b0;
        accept       = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (trig_edge && enable) begin
                    accept      = 1'b1;
                    // Header captures pre-update values of every counter.
                    meta_d      = META_DATA_WIDTH'({missed_cnt_q,
                                                    16'(n_samples),
                                                    arp_cnt_q,
                                                    acp_cnt_q,
                                                    ts_q,
                                                    trig_cnt_q});
                    delay_cnt_d = delay;
                    samp_cnt_d  = n_samples;
                    trig_cnt_d  = trig_cnt_q + 32'd1;
                    state_d     = S_INIT;
                end
            end
            S_INIT: begin
                // Any strobe during the header cycle is dropped.
                if (delay_cnt_q != '0) begin
                    state_d = S_DELAY;
                end else if (samp_cnt_q != '0) begin
                    state_d = S_CAPTURE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_DELAY: begin
                if (strobe_in) begin
                    delay_cnt_d = delay_cnt_q - CNT_WIDTH'(1);
                    if (delay_cnt_q == CNT_WIDTH'(1)) begin
                        state_d = (samp_cnt_q != '0) ? S_CAPTURE : S_IDLE;
                    end
                end
            end
            S_CAPTURE: begin
                if (strobe_in) begin
                    strobe_out_d = 1'b1;
                    data_out_d   = data_in;
                    samp_cnt_d   = samp_cnt_q - CNT_WIDTH'(1);
                    if (samp_cnt_q == CNT_WIDTH'(1)) begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Disabling abandons any pulse in progress; no sample escapes.
        if (!enable) begin
            state_d      = S_IDLE;
            strobe_out_d = 1'b0;
            data_out_d   = data_out_q;
        end

        // Triggers that arrive while busy or disabled are tallied so the
        // next header reports how many pulses were lost.
        if (trig_edge) begin
            if (accept) begin
                missed_cnt_d = '0;
            end else if (missed_cnt_q != c_MISSED_MAX) begin
                missed_cnt_d = missed_cnt_q + 16'd1;
            end
        end
    end

    assign init       = (state_q == S_INIT) && enable;
    assign busy       = (state_q != S_IDLE);
    assign meta_data  = meta_q;
    assign data_out   = data_out_q;
    assign strobe_out = strobe_out_q;

endmodule
`default_nettype wire

// File: doc/pulse_capture_gate.md
Name: pulse_capture_gate

Overview:
- Sits directly upstream of the metadata-packing sample buffer in the radar receive chain.
- On each radar trigger, snapshots per-pulse metadata (trigger count, timestamp, azimuth counts, dropped-trigger count) onto meta_data and pulses init, so the buffer loads that header.
- Skips a programmable number of samples, then forwards exactly n_samples strobed samples.
- Idles until the next trigger.

Parameters:
- data_width, 16, sample word width passed through unchanged.
- meta_data_width, 128, width of meta_data; fixed at 128 by the layout below.
- cnt_width, 16, width of the delay, n_samples and sample counters.

Ports:
- clock  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- enable  input  1  block enable; low forces IDLE.
- trig_in  input  1  raw radar trigger, asynchronous.
- acp_in  input  1  raw azimuth count pulse, asynchronous.
- arp_in  input  1  raw azimuth reset pulse (heading), asynchronous.
- data_in  input  data_width  sample from the decimator.
- strobe_in  input  1  data_in valid, one cycle per sample.
- delay  input  cnt_width  samples to discard after trigger; latched at trigger.
- n_samples  input  cnt_width  samples to forward per pulse; latched at trigger.
- init  output  1  one-cycle pulse; meta_data is valid in the same cycle.
- meta_data  output  128  per-pulse header.
- data_out  output  data_width  forwarded sample.
- strobe_out  output  1  data_out valid.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset: all outputs 0; state IDLE; all internal counters 0.
- Input conditioning: trig_in, acp_in and arp_in each pass through a 2-flop synchronizer followed by a rising-edge detector. The edge event is a 1-cycle pulse, 3 clocks after the input rises.
- Free-running counters (run regardless of enable):
  - ts: 32-bit, +1 per clock, wraps.
  - acp_cnt: 16-bit, +1 per ACP edge, wraps; cleared to 0 on an ARP edge. ARP wins when ACP and ARP edges coincide.
  - arp_cnt: 16-bit, +1 per ARP edge, wraps.
- Meta layout, all values sampled in the trigger-edge cycle, before any same-cycle update:
  - [31:0] trig_cnt (accepted triggers so far; first pulse = 0).
  - [63:32] ts.
  - [79:64] acp_cnt.
  - [95:80] arp_cnt.
  - [111:96] latched n_samples.
  - [127:112] missed_cnt.
- missed_cnt: 16-bit, saturates at 0xFFFF; +1 for each trigger edge that arrives while not in IDLE or while enable is low.
- FSM:
  - IDLE: on trigger edge with enable, register the meta word, latch delay and n_samples, go to INIT. In the same transition clear missed_cnt (its captured value is kept in meta) and increment trig_cnt.
  - INIT: init=1 for exactly this cycle with meta_data valid. meta_data holds its value until the next accepted trigger. Go to DELAY if latched delay != 0; otherwise go to CAPTURE if n_samples != 0, else IDLE.
  - DELAY: each strobe_in decrements the delay count. The strobe that reaches 0 is discarded. Then go to CAPTURE if n_samples != 0, else IDLE.
  - CAPTURE: each strobe_in gives data_out <= data_in and strobe_out=1 on the next clock (latency 1). After the n_samples-th strobe, go to IDLE.
  - strobe_out is 0 in every other cycle. data_out holds its last value when not strobing.
- A strobe_in coinciding with init (INIT state) is discarded. Sample counting starts with the first strobe after INIT.
- enable low in any state: next state IDLE, strobe_out=0, init=0. No partial-pulse completion. A capture in flight is truncated.
- reset asserted mid-pulse: immediate return to the reset values above.
- delay and n_samples changing mid-pulse have no effect on the current pulse.

Test Plan:
- Reset, enable=1, delay=2, n_samples=4, strobe_in every 4th clock, one trig_in rise:
  - init pulses once.
  - meta[31:0]=0, meta[111:96]=4.
  - Exactly 4 strobe_out pulses, carrying samples 3..6 after the trigger, each 1 clock after its strobe_in.
  - busy drops after the 4th.
- 5 ACP pulses, 1 ARP pulse, 3 ACP pulses, then trigger -> meta[79:64]=3, meta[95:80]=1. Simultaneous ACP+ARP edge -> acp_cnt=0.
- n_samples=100, second trigger at sample 50 -> no second init; next accepted pulse has meta[127:112]=1, meta[31:0]=1; missed_cnt then reads back 0 on the following pulse.
- delay=0, n_samples=0, trigger -> single init pulse, no strobe_out, busy high for exactly 1 cycle (INIT).
- enable dropped after 10 of 20 samples -> strobe_out stops within 1 clock, busy=0. Trigger while enable=0 increments missed_cnt.
- Assert reset during CAPTURE -> init, strobe_out, data_out, meta_data and busy all 0 in the same cycle. The next trigger produces meta[31:0]=0 and meta[63:32] counted from reset release.
